// File: rtl/vc_intc.sv
// vc_intc: NSRC-source interrupt controller for the VC I/O bus, with claim/EOI nesting.
// Defining VC_INTC_SYNC_EN puts a two-flop synchroniser on each src line.
module vc_intc #(
    parameter int RV   = 16,
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [3:0]      io_addr,
    input  logic            io_write,
    input  logic            io_read,
    input  logic [RV-1:0]   io_wdata,
    output logic [RV-1:0]   io_rdata,
    output logic            interrupt
);

    typedef enum logic [3:0] {
        REG_PEND   = 4'd0,
        REG_ENABLE = 4'd1,
        REG_MODE   = 4'd2,
        REG_CLAIM  = 4'd3,
        REG_SWINT  = 4'd4,
        REG_INSERV = 4'd5
    } reg_e;

    reg_e            addr_e;
    logic [NSRC-1:0] src_s;
    logic [NSRC-1:0] src_d_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] inserv_q, inserv_d;
    logic            interrupt_q;

    logic [NSRC-1:0] rise, set, clr, swset, w1c;
    logic [NSRC-1:0] pend, elig, below_inserv, first_hot, claim_hot, eoi_hot;
    logic [3:0]      best;
    logic            any_elig;
    logic            wr_pend, wr_enable, wr_mode, wr_claim, wr_swint, rd_claim;
    logic            unused_wdata;

    assign addr_e = reg_e'(io_addr);

`ifdef VC_INTC_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src;
`endif

    assign wr_pend   = io_write && (addr_e == REG_PEND);
    assign wr_enable = io_write && (addr_e == REG_ENABLE);
    assign wr_mode   = io_write && (addr_e == REG_MODE);
    assign wr_claim  = io_write && (addr_e == REG_CLAIM);
    assign wr_swint  = io_write && (addr_e == REG_SWINT);
    assign rd_claim  = io_read  && (addr_e == REG_CLAIM);

    assign unused_wdata = ^io_wdata;

    assign rise  = src_s & ~src_d_q;
    assign swset = wr_swint ? io_wdata[NSRC-1:0] : '0;
    assign w1c   = wr_pend  ? io_wdata[NSRC-1:0] : '0;
    assign set   = (rise & mode_q) | swset;
    assign clr   = w1c | claim_hot;

    // Level sources are not latched: they are seen only while the line is high.
    assign pend = pend_q | (~mode_q & src_s);

    always_comb begin
        logic seen;
        logic found;
        seen         = 1'b0;
        found        = 1'b0;
        below_inserv = '0;
        first_hot    = '0;
        best         = '0;
        eoi_hot      = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            seen            = seen | inserv_q[k];
            below_inserv[k] = ~seen;
        end
        elig = pend & enable_q & below_inserv;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (elig[k] && !found) begin
                found        = 1'b1;
                best         = 4'(k);
                first_hot[k] = 1'b1;
            end
            eoi_hot[k] = wr_claim && (io_wdata[3:0] == 4'(k));
        end
        any_elig  = found;
        claim_hot = rd_claim ? first_hot : '0;
    end

    always_comb begin
        pend_d   = (pend_q & ~clr) | set;
        inserv_d = (inserv_q & ~eoi_hot) | claim_hot;
        enable_d = wr_enable ? io_wdata[NSRC-1:0] : enable_q;
        mode_d   = wr_mode   ? io_wdata[NSRC-1:0] : mode_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_d_q     <= '0;
            pend_q      <= '0;
            enable_q    <= '0;
            mode_q      <= '0;
            inserv_q    <= '0;
            interrupt_q <= 1'b0;
        end else begin
            src_d_q     <= src_s;
            pend_q      <= pend_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            inserv_q    <= inserv_d;
            interrupt_q <= any_elig;
        end
    end

    assign interrupt = interrupt_q;

    always_comb begin
        io_rdata = '0;
        case (addr_e)
            REG_PEND:   io_rdata[NSRC-1:0] = pend;
            REG_ENABLE: io_rdata[NSRC-1:0] = enable_q;
            REG_MODE:   io_rdata[NSRC-1:0] = mode_q;
            REG_CLAIM: begin
                if (any_elig) begin
                    io_rdata[RV-1] = 1'b1;
                    io_rdata[3:0]  = best;
                end
            end
            REG_INSERV: io_rdata[NSRC-1:0] = inserv_q;
            default:    io_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_vc_intc.sv
// Directed bench for vc_intc (RV=16, NSRC=8); src latency follows VC_INTC_SYNC_EN.
module tb_vc_intc;

    localparam int RV   = 16;
    localparam int NSRC = 8;
`ifdef VC_INTC_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] src;
    logic [3:0]      io_addr;
    logic            io_write;
    logic            io_read;
    logic [RV-1:0]   io_wdata;
    logic [RV-1:0]   io_rdata;
    logic            interrupt;

    int n_cmp = 0;
    int n_err = 0;

    vc_intc #(.RV(RV), .NSRC(NSRC)) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .io_addr   (io_addr),
        .io_write  (io_write),
        .io_read   (io_read),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [RV-1:0] d);
        io_addr  = a;
        io_wdata = d;
        io_write = 1'b1;
        tick();
        io_write = 1'b0;
        io_wdata = '0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [RV-1:0] d);
        io_addr = a;
        io_read = 1'b1;
        @(negedge clk);
        d = io_rdata;
        tick();
        io_read = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, output logic [RV-1:0] d);
        io_addr = a;
        #1;
        d = io_rdata;
    endtask

    logic [RV-1:0] d;

    initial begin
        reset    = 1'b1;
        src      = '0;
        io_addr  = '0;
        io_write = 1'b0;
        io_read  = 1'b0;
        io_wdata = '0;
        repeat (2) tick();
        reset = 1'b0;

        // reset state
        check("rst_irq", 32'(interrupt), 32'h0);
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), d);
            check($sformatf("rst_reg%0d", i), 32'(d), 32'h0);
        end

        // edge latency
        wr(4'd2, 16'h0001);
        wr(4'd1, 16'h0001);
        src[0] = 1'b1;
        peek(4'd0, d); check("edge_pend_pre", 32'(d), 32'h0);
        repeat (SL) begin
            tick();
            peek(4'd0, d); check("edge_pend_sync", 32'(d), 32'h0);
        end
        tick();
        peek(4'd0, d); check("edge_pend_N", 32'(d), 32'h0001);
        check("edge_irq_N", 32'(interrupt), 32'h0);
        tick();
        check("edge_irq_N1", 32'(interrupt), 32'h1);
        rd(4'd3, d); check("edge_claim", 32'(d), 32'h8000);
        peek(4'd0, d); check("edge_pend_claimed", 32'(d), 32'h0);
        peek(4'd5, d); check("edge_inserv", 32'(d), 32'h0001);
        check("edge_irq_hold", 32'(interrupt), 32'h1);
        tick();
        check("edge_irq_drop", 32'(interrupt), 32'h0);
        wr(4'd3, 16'h0000);
        peek(4'd5, d); check("edge_eoi", 32'(d), 32'h0);
        src[0] = 1'b0;
        repeat (SL + 1) tick();

        // priority and nesting
        wr(4'd2, 16'h00FF);
        wr(4'd1, 16'h00FF);
        wr(4'd4, 16'h0024);
        peek(4'd4, d); check("swint_reads0", 32'(d), 32'h0);
        rd(4'd3, d); check("nest_claim2", 32'(d), 32'h8002);
        tick();
        check("nest_mask5", 32'(interrupt), 32'h0);
        wr(4'd4, 16'h0001);
        tick();
        check("nest_irq0", 32'(interrupt), 32'h1);
        rd(4'd3, d); check("nest_claim0", 32'(d), 32'h8000);
        peek(4'd5, d); check("nest_inserv", 32'(d), 32'h0005);
        rd(4'd3, d); check("claim_none", 32'(d), 32'h0);
        peek(4'd5, d); check("claim_none_inserv", 32'(d), 32'h0005);
        wr(4'd3, 16'h0000);
        peek(4'd3, d); check("nest_still_masked", 32'(d), 32'h0);
        wr(4'd3, 16'h0002);
        rd(4'd3, d); check("nest_claim5", 32'(d), 32'h8005);
        peek(4'd5, d); check("nest_inserv5", 32'(d), 32'h0020);
        wr(4'd3, 16'h000F);
        peek(4'd5, d); check("eoi15_ignored", 32'(d), 32'h0020);
        wr(4'd3, 16'h0005);
        peek(4'd5, d); check("eoi5", 32'(d), 32'h0);
        peek(4'd0, d); check("nest_pend_empty", 32'(d), 32'h0);
        tick();
        check("nest_irq_idle", 32'(interrupt), 32'h0);

        // level source
        wr(4'd2, 16'h0000);
        wr(4'd1, 16'h0008);
        src[3] = 1'b1;
        repeat (SL) tick();
        peek(4'd0, d); check("lvl_pend", 32'(d), 32'h0008);
        tick();
        check("lvl_irq", 32'(interrupt), 32'h1);
        rd(4'd3, d); check("lvl_claim", 32'(d), 32'h8003);
        tick();
        check("lvl_irq_masked", 32'(interrupt), 32'h0);
        wr(4'd0, 16'h0008);
        peek(4'd0, d); check("lvl_w1c_noeffect", 32'(d), 32'h0008);
        check("lvl_irq_still_masked", 32'(interrupt), 32'h0);
        wr(4'd3, 16'h0003);
        tick();
        check("lvl_irq_reassert", 32'(interrupt), 32'h1);
        src[3] = 1'b0;
        repeat (SL + 1) tick();
        check("lvl_irq_release", 32'(interrupt), 32'h0);
        peek(4'd0, d); check("lvl_pend_release", 32'(d), 32'h0);

        // set beats clear, disabled pending source
        wr(4'd2, 16'h0002);
        wr(4'd1, 16'h0000);
        src[1] = 1'b1;
        repeat (SL) tick();
        wr(4'd0, 16'h0002);
        peek(4'd0, d); check("set_beats_clr", 32'(d), 32'h0002);
        tick();
        check("disabled_no_irq", 32'(interrupt), 32'h0);
        wr(4'd1, 16'h0002);
        tick();
        check("enabled_irq", 32'(interrupt), 32'h1);
        wr(4'd0, 16'h0002);
        peek(4'd0, d); check("edge_w1c", 32'(d), 32'h0);
        src[1] = 1'b0;
        repeat (SL + 1) tick();

        // reset while pending
        wr(4'd1, 16'h00FF);
        wr(4'd4, 16'h0010);
        tick();
        check("pre_rst_irq", 32'(interrupt), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_irq", 32'(interrupt), 32'h0);
        for (int i = 0; i < 6; i++) begin
            peek(4'(i), d);
            check($sformatf("mid_rst_reg%0d", i), 32'(d), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
